tmds_decode_align: RTL and testbench

// - Receive-side counterpart of the TMDS encode path: one instance per TMDS data channel.
// - Takes 10-bit parallel words from the channel deserializer.
// - Finds symbol alignment by hunting for control-token runs, commanding bitslips as needed.
// - Decodes aligned words back to 8-bit pixel data, or 2-bit control plus an active flag.
// - DVI-only: data islands and guard bands are not recognised; such words decode as video.

---
 rtl/tmds_pkg.sv | 19 +
 rtl/tmds_symbol_decode.sv | 35 +++
 rtl/tmds_decode_align.sv | 165 ++++++++++++++++
 tb/tb_tmds_decode_align.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment FSM states and the decoded symbol record.
package tmds_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

    // Index into this table is the {c1,c0} value the token carries.
    localparam logic [9:0] CTL_TOKEN [0:3] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b symbol decoder: control-token match plus transition-minimised video decode.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym_i,
    output logic       is_token_o,
    output logic [1:0] ctl_o,
    output logic [7:0] pdata_o
);

    logic [7:0] q_s;

    // Token match; pdata_o is always the video interpretation and is discarded by the caller for tokens.
    always_comb begin
        is_token_o = 1'b0;
        ctl_o      = 2'b00;
        pdata_o    = 8'h00;
        q_s        = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];

        case (sym_i)
            CTL_TOKEN[0]: begin is_token_o = 1'b1; ctl_o = 2'b00; end
            CTL_TOKEN[1]: begin is_token_o = 1'b1; ctl_o = 2'b01; end
            CTL_TOKEN[2]: begin is_token_o = 1'b1; ctl_o = 2'b10; end
            CTL_TOKEN[3]: begin is_token_o = 1'b1; ctl_o = 2'b11; end
            default:      begin is_token_o = 1'b0; ctl_o = 2'b00; end
        endcase

        // Bit 8 selects XOR or XNOR chaining used by the encoder.
        pdata_o[0] = q_s[0];
        for (int i = 1; i < 8; i++) begin
            pdata_o[i] = sym_i[8] ? (q_s[i] ^ q_s[i-1]) : ~(q_s[i] ^ q_s[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decode_align.sv
// TMDS receive channel: word alignment via control-token runs with bitslip, then 10b->8b decode.
module tmds_decode_align
    import tmds_pkg::*;
#(
    parameter int CTL_RUN        = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_SETTLE    = 4,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] tmds_data,
    output logic       bitslip,
    output logic       aligned,
    output logic [3:0] slip_count,
    output logic       active,
    output logic [7:0] pdata,
    output logic [1:0] ctl
);

    localparam int RUN_W  = $clog2(CTL_RUN + 1);
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int SET_W  = $clog2(SLIP_SETTLE + 1);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

    align_state_t      state_q, state_d;
    logic [9:0]        sym_q;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic [3:0]        slip_cnt_q, slip_cnt_d;
    logic              bitslip_q, bitslip_d;
    logic              aligned_q, aligned_d;
    logic              active_q, active_d;
    logic [7:0]        pdata_q, pdata_d;
    logic [1:0]        ctl_q, ctl_d;

    logic              tok_s;
    logic [1:0]        tok_ctl_s;
    logic [7:0]        dec_pdata_s;

    tmds_symbol_decode u_decode (
        .sym_i      (sym_q),
        .is_token_o (tok_s),
        .ctl_o      (tok_ctl_s),
        .pdata_o    (dec_pdata_s)
    );

    // Next-state, counters and gated stage-2 outputs.
    always_comb begin
        state_d    = state_q;
        tmo_d      = '0;
        set_d      = '0;
        loss_d     = '0;
        slip_cnt_d = slip_cnt_q;

        if (tok_s) begin
            run_d = (run_q == RUN_W'(CTL_RUN)) ? run_q : run_q + RUN_W'(1);
        end else begin
            run_d = '0;
        end

        case (state_q)
            SEARCH: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A completed run takes priority over a simultaneous timeout.
                if (run_d == RUN_W'(CTL_RUN)) begin
                    state_d    = LOCKED;
                    slip_cnt_d = 4'd0;
                end else if (tmo_q == TMO_W'(SEARCH_TIMEOUT - 1)) begin
                    state_d = SLIP;
                end else begin
                    state_d = SEARCH;
                end
            end
            SLIP: begin
                run_d      = '0;
                slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
                state_d    = WAIT;
            end
            WAIT: begin
                run_d = '0;
                set_d = set_q + SET_W'(1);
                if (set_q == SET_W'(SLIP_SETTLE - 1)) begin
                    state_d = SEARCH;
                end else begin
                    state_d = WAIT;
                end
            end
            LOCKED: begin
                if (tok_s) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_W'(LOSS_TIMEOUT - 1)) begin
                    state_d    = SEARCH;
                    slip_cnt_d = 4'd0;
                    run_d      = '0;
                end else begin
                    loss_d = loss_q + LOSS_W'(1);
                end
            end
            default: begin
                state_d = SEARCH;
                run_d   = '0;
            end
        endcase

        bitslip_d = (state_d == SLIP);
        aligned_d = (state_d == LOCKED);

        // Outputs are gated with the next aligned value so they change together with it.
        if (!aligned_d) begin
            active_d = 1'b0;
            pdata_d  = 8'h00;
            ctl_d    = 2'b00;
        end else if (tok_s) begin
            active_d = 1'b0;
            pdata_d  = 8'h00;
            ctl_d    = tok_ctl_s;
        end else begin
            active_d = 1'b1;
            pdata_d  = dec_pdata_s;
            ctl_d    = ctl_q;
        end
    end

    // Stage-1 input register, FSM state, counters and stage-2 output registers.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEARCH;
            sym_q      <= 10'd0;
            run_q      <= '0;
            tmo_q      <= '0;
            set_q      <= '0;
            loss_q     <= '0;
            slip_cnt_q <= 4'd0;
            bitslip_q  <= 1'b0;
            aligned_q  <= 1'b0;
            active_q   <= 1'b0;
            pdata_q    <= 8'h00;
            ctl_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            sym_q      <= tmds_data;
            run_q      <= run_d;
            tmo_q      <= tmo_d;
            set_q      <= set_d;
            loss_q     <= loss_d;
            slip_cnt_q <= slip_cnt_d;
            bitslip_q  <= bitslip_d;
            aligned_q  <= aligned_d;
            active_q   <= active_d;
            pdata_q    <= pdata_d;
            ctl_q      <= ctl_d;
        end
    end

    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign slip_count = slip_cnt_q;
    assign active     = active_q;
    assign pdata      = pdata_q;
    assign ctl        = ctl_q;

endmodule

// File: tb/tb_tmds_decode_align.sv
// Self-checking bench for tmds_decode_align: directed alignment scenarios plus randomized decode.
module tb_tmds_decode_align;

    localparam int CTL_RUN        = 8;
    localparam int SEARCH_TIMEOUT = 4096;
    localparam int SLIP_SETTLE    = 4;
    localparam int LOSS_TIMEOUT   = 65536;
    localparam int SLIP_PERIOD    = SEARCH_TIMEOUT + SLIP_SETTLE + 1;

    localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                       10'b0101010100, 10'b1010101011};

    logic       pixel_clk = 1'b0;
    logic       rst       = 1'b1;
    logic [9:0] tmds_data = 10'd0;
    logic       bitslip;
    logic       aligned;
    logic [3:0] slip_count;
    logic       active;
    logic [7:0] pdata;
    logic [1:0] ctl;

    int errors = 0;
    int checks = 0;
    int slips  = 0;
    logic [9:0] cur_w  = 10'd0;
    logic [9:0] last_w = 10'd0;
    logic [1:0] held_ctl = 2'b00;

    tmds_decode_align dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .tmds_data  (tmds_data),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .slip_count (slip_count),
        .active     (active),
        .pdata      (pdata),
        .ctl        (ctl)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tok_index(input logic [9:0] w);
        for (int k = 0; k < 4; k++) if (w == TOK[k]) return k;
        return -1;
    endfunction

    // Inverse of the TMDS encoder: undo optional inversion, then undo the XOR/XNOR chain.
    function automatic logic [7:0] video_byte(input logic [9:0] w);
        logic [7:0] q, x;
        q = w[9] ? ~w[7:0] : w[7:0];
        x = q ^ {q[6:0], 1'b0};
        if (!w[8]) x = ~x;
        x[0] = q[0];
        return x;
    endfunction

    function automatic logic [9:0] rnd_video();
        logic [9:0] w;
        do w = 10'($urandom); while (tok_index(w) >= 0);
        return w;
    endfunction

    function automatic logic [9:0] rotw(input logic [9:0] w, input int r);
        logic [19:0] d;
        d = {w, w};
        return d[r +: 10];
    endfunction

    task automatic tick(input logic [9:0] w);
        last_w    = cur_w;
        cur_w     = w;
        tmds_data = w;
        @(posedge pixel_clk);
        #1;
        if (bitslip === 1'b1) slips++;
    endtask

    // Checks the decoded outputs against the word presented two edges earlier.
    task automatic out_chk(input string tag);
        int k;
        k = tok_index(last_w);
        if (k >= 0) begin
            held_ctl = k[1:0];
            chk({tag, "_act"}, active, 0);
            chk({tag, "_pd"}, pdata, 0);
        end else begin
            chk({tag, "_act"}, active, 1);
            chk({tag, "_pd"}, pdata, video_byte(last_w));
        end
        chk({tag, "_ctl"}, ctl, held_ctl);
        chk({tag, "_al"}, aligned, 1);
    endtask

    task automatic relock(input string tag);
        for (int i = 1; i <= CTL_RUN + 1; i++) begin
            tick(TOK[0]);
            if (i == CTL_RUN) chk({tag, "_pre"}, aligned, 0);
        end
        chk({tag, "_al"}, aligned, 1);
        chk({tag, "_act"}, active, 0);
        chk({tag, "_ctl"}, ctl, 0);
        chk({tag, "_pd"}, pdata, 0);
        chk({tag, "_sc"}, slip_count, 0);
        held_ctl = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bs"}, bitslip, 0);
        chk({tag, "_al"}, aligned, 0);
        chk({tag, "_sc"}, slip_count, 0);
        chk({tag, "_act"}, active, 0);
        chk({tag, "_pd"}, pdata, 0);
        chk({tag, "_ctl"}, ctl, 0);
    endtask

    initial begin
        int p1, p2, p3, lock_at, rot, n;

        // Reset state
        repeat (3) @(posedge pixel_clk);
        #1;
        chk_all_zero("reset");
        #1 rst = 1'b0;

        // Aligned token stream locks within CTL_RUN+2 cycles, no bitslip
        slips = 0;
        relock("lock0");
        chk("lock0_noslip", slips, 0);

        // Directed video words
        tick(10'h100);
        tick(10'h2FF);
        out_chk("v100");
        chk("v100_const", pdata, 8'h00);
        tick(TOK[0]);
        out_chk("v2ff");
        chk("v2ff_const", pdata, 8'hFE);

        // Each control token in turn
        for (int k = 0; k < 4; k++) begin
            tick(TOK[k]);
            if (k > 0) out_chk("tokseq");
        end
        tick(rnd_video());
        out_chk("tok3");
        chk("tok3_const", ctl, 2'b11);

        // Randomized mix of video and tokens while locked
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 7) == 0) ? TOK[$urandom_range(0, 3)] : rnd_video());
            out_chk("rand");
        end

        // Loss of lock after LOSS_TIMEOUT video-only cycles
        tick(TOK[1]);
        for (int i = 0; i < LOSS_TIMEOUT; i++) tick(rnd_video());
        chk("loss_edge_al", aligned, 1);
        tick(rnd_video());
        chk("loss_al", aligned, 0);
        chk("loss_act", active, 0);
        chk("loss_pd", pdata, 0);
        chk("loss_ctl", ctl, 0);
        chk("loss_sc", slip_count, 0);
        relock("relock_loss");

        // Asynchronous reset mid-LOCKED during video
        repeat (5) tick(rnd_video());
        #3 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge pixel_clk);
        #2 rst = 1'b0;
        cur_w = 10'd0;
        relock("relock_rst");

        // Misaligned stream: bench deserializer honours bitslip
        rst = 1'b1;
        @(posedge pixel_clk);
        #2 rst = 1'b0;
        rot = 3; slips = 0; n = 0; p1 = 0; p2 = 0; p3 = 0; lock_at = -1;
        for (int c = 0; c < 4 * SLIP_PERIOD + 200 && lock_at < 0; c++) begin
            tick(rotw(TOK[0], rot));
            if (bitslip === 1'b1) begin
                n++;
                if (n == 1) p1 = c;
                if (n == 2) p2 = c;
                if (n == 3) p3 = c;
                rot = (rot + 9) % 10;
                tick(rotw(TOK[0], rot));
                c++;
                chk("slip_cnt_inc", slip_count, n % 10);
                chk("slip_width", bitslip, 0);
            end
            if (aligned === 1'b1) lock_at = c;
        end
        chk("slip_pulses", n, 3);
        chk("slip_gap12", p2 - p1, SLIP_PERIOD);
        chk("slip_gap23", p3 - p2, SLIP_PERIOD);
        chk("slip_locked", aligned, 1);
        chk("slip_lock_soon", (lock_at > p3) && (lock_at - p3 <= CTL_RUN + SLIP_SETTLE + 4), 1);
        chk("slip_sc_zero", slip_count, 0);
        for (int i = 0; i < 50; i++) tick(TOK[0]);
        chk("slip_no_more", slips, 3);
        chk("slip_still_al", aligned, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
